// File: rtl/lut_interp_accum.sv
// Weighted-tap accumulator for the SR-LUT datapath: sums N_TAPS (weight x sample) products per
// pixel, rounds half-up, shifts right, and presents a signed 32-bit result with valid/ready.
module lut_interp_accum #(
  parameter int unsigned N_TAPS = 4,
  parameter int unsigned W_BITS = 7,
  parameter int unsigned V_BITS = 8,
  parameter int unsigned SHIFT  = 6,
  localparam int unsigned TapW  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_BITS-1:0]        in_weight,
  input  logic signed [V_BITS-1:0] in_lut,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [31:0]       out_data,
  output logic [TapW-1:0]          tap_idx
);

  localparam int unsigned ProdW = W_BITS + V_BITS + 1;
  localparam logic [TapW-1:0] LastIdx = TapW'(N_TAPS - 1);

  if (N_TAPS < 1) begin : g_bad_taps
    $error("lut_interp_accum: N_TAPS must be at least 1");
  end
  if (ProdW > 32) begin : g_bad_width
    $error("lut_interp_accum: product does not fit in 32 bits");
  end

  typedef enum logic {StAcc, StHold} out_state_e;

  out_state_e              out_st_q, out_st_d;
  logic [TapW-1:0]         tap_idx_q, tap_idx_d;
  logic signed [31:0]      acc_q, acc_d;
  logic signed [31:0]      out_data_q, out_data_d;

  logic                    tap_accept;
  logic                    last_tap;
  logic signed [ProdW-1:0] weight_ext;
  logic signed [ProdW-1:0] lut_ext;
  logic signed [ProdW-1:0] prod_c;
  logic signed [31:0]      prod32_c;
  logic signed [31:0]      base_c;
  logic signed [31:0]      sum_c;
  logic signed [31:0]      result_c;

  assign in_ready   = (out_st_q != StHold) || out_ready;
  assign tap_accept = in_valid && in_ready;
  assign last_tap   = (tap_idx_q == LastIdx);

  // Weight is unsigned, so it gets a zero MSB before the signed multiply.
  assign weight_ext = $signed({{(V_BITS + 1){1'b0}}, in_weight});
  assign lut_ext    = $signed({{(W_BITS + 1){in_lut[V_BITS-1]}}, in_lut});
  assign prod_c     = weight_ext * lut_ext;
  assign prod32_c   = 32'(prod_c);

  // First tap of a pixel restarts the sum instead of adding to the old one.
  assign base_c = (tap_idx_q == '0) ? 32'sd0 : acc_q;
  assign sum_c  = base_c + prod32_c;

  if (SHIFT == 0) begin : g_no_shift
    assign result_c = sum_c;
  end else begin : g_round_shift
    localparam logic signed [31:0] RoundBias = 32'sd1 <<< (SHIFT - 1);
    assign result_c = (sum_c + RoundBias) >>> SHIFT;
  end

  always_comb begin
    out_st_d   = out_st_q;
    tap_idx_d  = tap_idx_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;

    if (tap_accept) begin
      tap_idx_d = last_tap ? '0 : tap_idx_q + TapW'(1);
      acc_d     = sum_c;
    end

    // A final tap wins over acceptance so back-to-back results keep out_valid high.
    if (tap_accept && last_tap) begin
      out_st_d   = StHold;
      out_data_d = result_c;
    end else if ((out_st_q == StHold) && out_ready) begin
      out_st_d = StAcc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_st_q   <= StAcc;
      tap_idx_q  <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      out_st_q   <= out_st_d;
      tap_idx_q  <= tap_idx_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (out_st_q == StHold);
  assign out_data  = out_data_q;
  assign tap_idx   = tap_idx_q;

endmodule

// File: tb/tb_lut_interp_accum.sv
// Directed bench for lut_interp_accum: a 4-tap instance for pixel arithmetic, backpressure and
// reset, plus a 1-tap instance for results that are accepted and reloaded in the same cycle.
module tb_lut_interp_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_weight;
  logic signed [7:0]  in_lut;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [1:0]         tap_idx;

  logic               s_valid;
  logic               s_ready;
  logic [6:0]         s_weight;
  logic signed [7:0]  s_lut;
  logic               s_out_valid;
  logic               s_out_ready;
  logic signed [31:0] s_out_data;
  logic [0:0]         s_tap_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lut_interp_accum #(.N_TAPS(4), .W_BITS(7), .V_BITS(8), .SHIFT(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_weight (in_weight),
    .in_lut    (in_lut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .tap_idx   (tap_idx)
  );

  lut_interp_accum #(.N_TAPS(1), .W_BITS(7), .V_BITS(8), .SHIFT(6)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_weight (s_weight),
    .in_lut    (s_lut),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .tap_idx   (s_tap_idx)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int clamp_s6(input int x);
    if (x > 31) return 31;
    if (x < -32) return -32;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one tap for exactly one edge; caller guarantees in_ready is high.
  task automatic send_tap(input int w, input int l);
    in_valid  = 1'b1;
    in_weight = 7'(w);
    in_lut    = 8'(l);
    check_val("tap_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pixel(input string tag, input int w0, input int w1, input int w2, input int w3,
                       input int l0, input int l1, input int l2, input int l3, input int exp);
    int ws[4];
    int ls[4];
    ws = '{w0, w1, w2, w3};
    ls = '{l0, l1, l2, l3};
    for (int i = 0; i < 4; i++) begin
      send_tap(ws[i], ls[i]);
      if (i < 3) begin
        check_val({tag, "_idx"}, int'(tap_idx), i + 1);
        check_val({tag, "_vlow"}, int'(out_valid), 0);
      end
    end
    check_val({tag, "_valid"}, int'(out_valid), 1);
    check_val({tag, "_data"}, out_data, exp);
    check_val({tag, "_idx0"}, int'(tap_idx), 0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    check_val({tag, "_drained"}, int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_weight = '0; in_lut = '0; out_ready = 1'b0;
    s_valid = 1'b0; s_weight = '0; s_lut = '0; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_idx", int'(tap_idx), 0);
    check_val("rst_ready", int'(in_ready), 1);

    // (1600+32)>>>6 = 25; result held while out_ready is low.
    pixel("basic", 16, 16, 16, 16, 10, 20, 30, 40, 25);
    check_val("hold_ready", int'(in_ready), 0);
    drain("basic");

    pixel("neg_round", 64, 0, 0, 0, -10, 5, 5, 5, -10);
    drain("neg_round");
    pixel("neg_half", 32, 0, 0, 0, -1, 0, 0, 0, 0);
    drain("neg_half");
    pixel("big_pos", 64, 64, 64, 64, 127, 127, 127, 127, 508);
    check_val("clamp_pos", clamp_s6(out_data), 31);
    drain("big_pos");
    pixel("big_neg", 64, 64, 64, 64, -128, -128, -128, -128, -512);
    check_val("clamp_neg", clamp_s6(out_data), -32);
    drain("big_neg");
    // -5000+2970-51+3520 = 1439; (1439+32)>>>6 = 22
    pixel("mixed", 50, 33, 17, 64, -100, 90, -3, 55, 22);

    // Backpressure: next pixel's first tap waits on the held result.
    in_valid = 1'b1; in_weight = 7'd64; in_lut = 8'sd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_ready", int'(in_ready), 0);
      check_val("bp_valid", int'(out_valid), 1);
      check_val("bp_data", out_data, 22);
      check_val("bp_idx", int'(tap_idx), 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("bp_release_valid", int'(out_valid), 0);
    check_val("bp_release_idx", int'(tap_idx), 1);
    send_tap(64, 6);
    send_tap(0, 0);
    send_tap(0, 0);
    check_val("bp_valid2", int'(out_valid), 1);
    check_val("bp_data2", out_data, 11);

    // Back-to-back pixels with out_ready held high.
    pixel("b2b_a", 16, 16, 16, 16, 10, 20, 30, 40, 25);
    pixel("b2b_b", 64, 0, 0, 0, -10, 5, 5, 5, -10);
    pixel("b2b_c", 64, 64, 64, 64, 127, 127, 127, 127, 508);
    step();
    check_val("b2b_end_valid", int'(out_valid), 0);

    // Reset after two taps, asserted together with a third tap.
    send_tap(64, 100);
    send_tap(64, 100);
    in_valid = 1'b1; in_weight = 7'd64; in_lut = 8'sd100;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check_val("midrst_idx", int'(tap_idx), 0);
    check_val("midrst_valid", int'(out_valid), 0);
    check_val("midrst_data", out_data, 0);
    pixel("after_rst", 64, 0, 0, 0, 3, 9, 9, 9, 3);
    step();

    // Single-tap instance: every tap yields a result; accept and reload coincide.
    s_valid = 1'b1; s_weight = 7'd64; s_lut = 8'sd100;
    step();
    check_val("n1_valid_a", int'(s_out_valid), 1);
    check_val("n1_data_a", s_out_data, 100);
    s_weight = 7'd10; s_lut = -8'sd7;
    step();
    check_val("n1_valid_b", int'(s_out_valid), 1);
    check_val("n1_data_b", s_out_data, -1);
    s_weight = 7'd33; s_lut = 8'sd50;
    step();
    check_val("n1_valid_c", int'(s_out_valid), 1);
    check_val("n1_data_c", s_out_data, 26);
    s_valid = 1'b0;
    step();
    check_val("n1_idle_valid", int'(s_out_valid), 0);
    check_val("n1_idx", int'(s_tap_idx), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
